// File: rtl/logic_l2_feed.sv
// logic_l2_feed
// ------------------------------------------------------------------------------
// Feeder stage for logic_l3. Bursty, valid-qualified words are collected in a
// small FIFO. The FIFO drains at most one word per cycle onto a data bus. On
// every cycle that does not drain, the bus carries all zeros, because logic_l3
// adds its input on every cycle. The block also reports the fill level, a count
// of drained words, and a sticky overflow flag.
//
// Ports
//   ib_clk       in   1                  clock, rising edge
//   ib_rst       in   1                  synchronous reset, active-high
//   ivG_data     in   PAR_DATA_BITS      upstream word
//   ib_valid     in   1                  ivG_data valid this cycle
//   ob_ready     out  1                  FIFO can accept a word (level != DEPTH)
//   ib_hold      in   1                  suppress draining while high
//   ovG_data     out  PAR_DATA_BITS      drained word, else all zeros
//   ob_valid     out  1                  ovG_data carries a drained word
//   ovG_level    out  PAR_DEPTH_LOG2+1   registered FIFO occupancy, 0..DEPTH
//   ovG_count    out  16                 drained words, modulo 2^16
//   ob_overflow  out  1                  sticky: word offered while full
// ------------------------------------------------------------------------------
module logic_l2_feed #(
  parameter int PAR_DATA_BITS  = 8,
  parameter int PAR_DEPTH_LOG2 = 2
) (
  input  logic                      ib_clk,
  input  logic                      ib_rst,
  input  logic [PAR_DATA_BITS-1:0]  ivG_data,
  input  logic                      ib_valid,
  output logic                      ob_ready,
  input  logic                      ib_hold,
  output logic [PAR_DATA_BITS-1:0]  ovG_data,
  output logic                      ob_valid,
  output logic [PAR_DEPTH_LOG2:0]   ovG_level,
  output logic [15:0]               ovG_count,
  output logic                      ob_overflow
);

  localparam int DEPTH = 1 << PAR_DEPTH_LOG2;
  localparam logic [PAR_DEPTH_LOG2:0]   LEVEL_FULL = (PAR_DEPTH_LOG2+1)'(DEPTH);
  localparam logic [PAR_DEPTH_LOG2:0]   LEVEL_ONE  = (PAR_DEPTH_LOG2+1)'(1);
  localparam logic [PAR_DEPTH_LOG2-1:0] PTR_ONE    = PAR_DEPTH_LOG2'(1);

  // Storage. The contents are intentionally left untouched by reset. Stale
  // entries are never read, because level gates every drain.
  logic [PAR_DATA_BITS-1:0] mem [DEPTH];

  logic [PAR_DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PAR_DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PAR_DEPTH_LOG2:0]   level_reg, level_next;
  logic [PAR_DATA_BITS-1:0]  data_reg, data_next;
  logic                      valid_reg, valid_next;
  logic [15:0]               count_reg, count_next;
  logic                      overflow_reg, overflow_next;

  logic accept;
  logic drain;

  // Ready depends only on the registered level. A full FIFO therefore refuses
  // a word even in a cycle where it also drains one.
  assign ob_ready = (level_reg != LEVEL_FULL);
  assign accept   = ib_valid && ob_ready;
  assign drain    = (level_reg != '0) && !ib_hold;

  // Next-state logic
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    level_next    = level_reg;
    data_next     = '0;
    valid_next    = 1'b0;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    if (accept) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end

    // A non-drain cycle leaves data_next at zero, so the accumulator adds +0.
    if (drain) begin
      data_next   = mem[rd_ptr_reg];
      valid_next  = 1'b1;
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
      count_next  = count_reg + 16'd1;
    end

    case ({accept, drain})
      2'b10:   level_next = level_reg + LEVEL_ONE;
      2'b01:   level_next = level_reg - LEVEL_ONE;
      default: level_next = level_reg;
    endcase

    if (ib_valid && !ob_ready) begin
      overflow_next = 1'b1;
    end
  end

  // Array write (no reset; the pointers alone define which entries are live)
  always_ff @(posedge ib_clk) begin
    if (!ib_rst && accept) begin
      mem[wr_ptr_reg] <= ivG_data;
    end
  end

  // State and output registers
  always_ff @(posedge ib_clk) begin
    if (ib_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  assign ovG_data    = data_reg;
  assign ob_valid    = valid_reg;
  assign ovG_level   = level_reg;
  assign ovG_count   = count_reg;
  assign ob_overflow = overflow_reg;

endmodule

// File: tb/tb_logic_l2_feed.sv
// Testbench for logic_l2_feed (DEPTH = 4, 8-bit data).
// A queue-based reference model predicts every output after every edge.
// Directed vectors also carry their own hand-derived expected values.
module tb_logic_l2_feed;

  localparam int DW    = 8;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;

  logic          ib_clk = 1'b0;
  logic          ib_rst = 1'b0;
  logic          ib_valid = 1'b0;
  logic          ib_hold = 1'b0;
  logic [DW-1:0] ivG_data = '0;
  logic          ob_ready;
  logic [DW-1:0] ovG_data;
  logic          ob_valid;
  logic [DL2:0]  ovG_level;
  logic [15:0]   ovG_count;
  logic          ob_overflow;

  logic_l2_feed #(.PAR_DATA_BITS(DW), .PAR_DEPTH_LOG2(DL2)) dut (
    .ib_clk(ib_clk), .ib_rst(ib_rst), .ivG_data(ivG_data), .ib_valid(ib_valid),
    .ob_ready(ob_ready), .ib_hold(ib_hold), .ovG_data(ovG_data),
    .ob_valid(ob_valid), .ovG_level(ovG_level), .ovG_count(ovG_count),
    .ob_overflow(ob_overflow)
  );

  always #5 ib_clk = ~ib_clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  int            m_count = 0;
  bit            m_ovf   = 1'b0;
  logic [DW-1:0] m_data  = '0;
  bit            m_valid = 1'b0;

  typedef struct {
    logic          rst, v, h;
    logic [DW-1:0] d;
    logic [DW-1:0] e_data;
    logic          e_valid;
    logic [DL2:0]  e_lvl;
    logic [15:0]   e_cnt;
    logic          e_ovf, e_rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, v, h, input logic [DW-1:0] d,
                     input logic [DW-1:0] e_data, input logic e_valid,
                     input logic [DL2:0] e_lvl, input logic [15:0] e_cnt,
                     input logic e_ovf, e_rdy);
    vec_t t;
    t.rst = rst; t.v = v; t.h = h; t.d = d;
    t.e_data = e_data; t.e_valid = e_valid; t.e_lvl = e_lvl;
    t.e_cnt = e_cnt; t.e_ovf = e_ovf; t.e_rdy = e_rdy;
    tbl.push_back(t);
  endtask

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic step(input logic rst, v, h, input logic [DW-1:0] d);
    bit rdy, drn;
    ib_rst = rst; ib_valid = v; ib_hold = h; ivG_data = d;
    @(posedge ib_clk);
    if (rst) begin
      mq.delete();
      m_count = 0; m_ovf = 1'b0; m_data = '0; m_valid = 1'b0;
    end else begin
      rdy = (mq.size() != DEPTH);
      drn = (mq.size() != 0) && !h;
      if (drn) begin
        m_data  = mq.pop_front();
        m_valid = 1'b1;
        m_count = (m_count + 1) % 65536;
      end else begin
        m_data  = '0;
        m_valid = 1'b0;
      end
      if (v && rdy)  mq.push_back(d);
      if (v && !rdy) m_ovf = 1'b1;
    end
    #1;
    $display("cyc rst=%0b v=%0b h=%0b d=%02h -> data=%02h vld=%0b lvl=%0d cnt=%0d ovf=%0b rdy=%0b",
             rst, v, h, d, ovG_data, ob_valid, ovG_level, ovG_count, ob_overflow, ob_ready);
    check("model_data",  32'(ovG_data),    32'(m_data));
    check("model_valid", 32'(ob_valid),    32'(m_valid));
    check("model_level", 32'(ovG_level),   32'(mq.size()));
    check("model_count", 32'(ovG_count),   32'(m_count));
    check("model_ovf",   32'(ob_overflow), 32'(m_ovf));
    check("model_ready", 32'(ob_ready),    32'(mq.size() != DEPTH));
  endtask

  initial begin
    logic [DW-1:0] exp_d;

    // Directed vectors: rst v h d | data valid level count ovf ready
    // Reset with traffic offered
    add(1,1,0,8'hFF, 8'h00,0,0,0,0,1);
    add(1,1,0,8'hFF, 8'h00,0,0,0,0,1);
    // Single word
    add(0,1,0,8'h5A, 8'h00,0,1,0,0,1);
    add(0,0,0,8'h00, 8'h5A,1,0,1,0,1);
    add(0,0,0,8'h00, 8'h00,0,0,1,0,1);
    // Fill with hold, then overflow
    add(0,1,1,8'h01, 8'h00,0,1,1,0,1);
    add(0,1,1,8'h02, 8'h00,0,2,1,0,1);
    add(0,1,1,8'h03, 8'h00,0,3,1,0,1);
    add(0,1,1,8'h04, 8'h00,0,4,1,0,0);
    add(0,1,1,8'h05, 8'h00,0,4,1,1,0);
    // Release hold
    add(0,0,0,8'h00, 8'h01,1,3,2,1,1);
    add(0,0,0,8'h00, 8'h02,1,2,3,1,1);
    add(0,0,0,8'h00, 8'h03,1,1,4,1,1);
    add(0,0,0,8'h00, 8'h04,1,0,5,1,1);
    add(0,0,0,8'h00, 8'h00,0,0,5,1,1);
    // Full with drain
    add(1,0,0,8'h00, 8'h00,0,0,0,0,1);
    add(0,1,1,8'h21, 8'h00,0,1,0,0,1);
    add(0,1,1,8'h22, 8'h00,0,2,0,0,1);
    add(0,1,1,8'h23, 8'h00,0,3,0,0,1);
    add(0,1,1,8'h24, 8'h00,0,4,0,0,0);
    add(0,1,0,8'h25, 8'h21,1,3,1,1,1);
    // Reset mid-operation, then a fresh word
    add(1,0,0,8'h00, 8'h00,0,0,0,0,1);
    add(0,1,0,8'hA5, 8'h00,0,1,0,0,1);
    add(0,0,0,8'h00, 8'hA5,1,0,1,0,1);
    add(0,0,0,8'h00, 8'h00,0,0,1,0,1);

    @(negedge ib_clk);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].h, tbl[i].d);
      check("vec_data",  32'(ovG_data),    32'(tbl[i].e_data));
      check("vec_valid", 32'(ob_valid),    32'(tbl[i].e_valid));
      check("vec_level", 32'(ovG_level),   32'(tbl[i].e_lvl));
      check("vec_count", 32'(ovG_count),   32'(tbl[i].e_cnt));
      check("vec_ovf",   32'(ob_overflow), 32'(tbl[i].e_ovf));
      check("vec_ready", 32'(ob_ready),    32'(tbl[i].e_rdy));
    end

    // Simultaneous accept and drain: preload two words, then stream 16 words.
    step(1, 0, 0, 8'h00);
    step(0, 1, 1, 8'h30);
    step(0, 1, 1, 8'h31);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 8'(8'h10 + i));
      if (i == 0)      exp_d = 8'h30;
      else if (i == 1) exp_d = 8'h31;
      else             exp_d = 8'(8'h10 + i - 2);
      check("stream_data",  32'(ovG_data),  32'(exp_d));
      check("stream_valid", 32'(ob_valid),  32'd1);
      check("stream_level", 32'(ovG_level), 32'd2);
    end
    step(0, 0, 0, 8'h00);
    check("stream_tail0", 32'(ovG_data), 32'h1E);
    step(0, 0, 0, 8'h00);
    check("stream_tail1", 32'(ovG_data), 32'h1F);
    check("stream_count", 32'(ovG_count), 32'd18);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 3),
           8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
